alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU in the npc datapath. It accepts operations from two independent requesters over valid/ready handshakes and picks one per transaction, round-robin by default. It drives the ALU with registered operands held stable for a full execute cycle, then captures result and flags. The captured response is returned on a shared response channel tagged with the requester ID.

## Interface
- DATA_LEN, 4, operand/result width; must match the ALU instance
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 transfer accepted this cycle
- req0_a, req0_b  input  DATA_LEN  requester 0 operands
- req0_op  input  4  requester 0 operator select
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a, alu_b  output  DATA_LEN  ALU operand drive
- alu_op  output  4  ALU operator_sel drive
- alu_result  input  DATA_LEN  ALU result
- alu_overflow, alu_zero, alu_carry  input  1  ALU flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  DATA_LEN  captured result
- rsp_overflow, rsp_zero, rsp_carry  output  1  captured flags
- busy  output  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among valid requesters and assert reqN_ready combinationally to the winner only.
  - On valid&ready, latch a/b/op and ID into operand registers, update the last-grant pointer, and go to EXEC.
- Arbitration:
  - Single requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
- EXEC:
  - alu_a/alu_b/alu_op come from the operand registers and are stable for the whole cycle.
  - At end of cycle, capture alu_result and the three flags into response registers, then go to RESP.
- RESP:
  - rsp_valid=1; response registers are held.
  - rsp_valid&rsp_ready goes to IDLE. Otherwise stay in RESP.
- No reqN_ready is asserted outside IDLE. Requesters must hold valid and payload stable until ready.
- alu_a/alu_b/alu_op keep their last latched values until the next accept. They are never driven with unlatched request data.
- Op codes 8–15 are forwarded unchanged. The ALU yields result 0 and zero=1, and these are returned as captured. There is no error flag.
- Flags are captured for every op; the consumer interprets carry only for op 0.

## Timing
- Reset values: every output 0 (req*_ready, rsp_*, alu_*, busy). Operand/response registers 0. Pointer 1. State IDLE.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is produced. rsp_valid drops the cycle after rst is sampled high.
- Latency: accept edge T → EXEC during cycle T+1 → rsp_valid high from cycle T+2.
- Minimum spacing between accepts is 3 cycles, with rsp_ready held high.
- rsp_ready low stalls in RESP indefinitely. Pending requests keep waiting and ready stays low.
- A request whose valid rises while in RESP is arbitrated on the first IDLE cycle.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins contention; the last-grant pointer is not implemented.
  - Requester 1 is granted only when req0_valid=0 in IDLE.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then idle: all outputs 0 for 5 cycles; busy=0.
- req0 a=4'h7 b=4'h9 op=0, rsp_ready=1 → EXEC drives alu_a=7, alu_b=9, alu_op=0. Response rsp_id=0, result=4'h0, carry=1, zero=1, 2 cycles after accept.
- req0 and req1 valid simultaneously and continuously, with 4 ops each → grants alternate 0,1,0,1,…; rsp_id sequence matches. With ALU_ARB_FIXED_PRIO_EN: all four req0 ops first, then req1.
- Hold rsp_ready=0 for 6 cycles during RESP while req1 is valid → rsp_valid and payload stable, req1_ready=0 throughout. Release, then req1 is accepted in the next IDLE cycle.
- Assert rst for 1 cycle while in EXEC → next cycle state IDLE, rsp_valid=0, no response for that op. The following req0 op=1 a=4'h5 b=4'h3 returns result=4'h2.
- req1 op=4'hC (unsupported) a=4'hF b=4'hF → response result=0, zero=1, rsp_id=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester valid/ready arbiter and sequencer for the shared 4-bit npc ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module alu_arbiter #(
   parameter int unsigned DATA_LEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [DATA_LEN-1:0] req0_a,
   input  logic [DATA_LEN-1:0] req0_b,
   input  logic [3:0]          req0_op,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [DATA_LEN-1:0] req1_a,
   input  logic [DATA_LEN-1:0] req1_b,
   input  logic [3:0]          req1_op,
   output logic [DATA_LEN-1:0] alu_a,
   output logic [DATA_LEN-1:0] alu_b,
   output logic [3:0]          alu_op,
   input  logic [DATA_LEN-1:0] alu_result,
   input  logic                alu_overflow,
   input  logic                alu_zero,
   input  logic                alu_carry,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [DATA_LEN-1:0] rsp_result,
   output logic                rsp_overflow,
   output logic                rsp_zero,
   output logic                rsp_carry,
   output logic                busy
);

   localparam int unsigned OP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_LEN-1:0] a_q;
   logic [DATA_LEN-1:0] b_q;
   logic [OP_W-1:0]     op_q;
   logic                id_q;
   logic                grant_c;
   logic                accept_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic                last_grant;
`endif

   // Winner selection: 0 = requester 0, 1 = requester 1 (only meaningful when someone is valid)
   always_comb begin
      grant_c = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_c = ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
         grant_c = ~last_grant;
      end else begin
         grant_c = req1_valid;
      end
`endif
   end

   // Next state and the combinational ready handshake (IDLE only, never while rst is sampled)
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               accept_c   = 1'b1;
               req0_ready = ~grant_c;
               req1_ready = grant_c;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand latch on accept, response capture at the end of EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= 1'b0;
         rsp_valid    <= 1'b0;
         busy         <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_carry    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant   <= 1'b1;
`endif
      end else begin
         rsp_valid <= (state_next == RESP);
         busy      <= (state_next != IDLE);
         if (accept_c) begin
            a_q        <= grant_c ? req1_a  : req0_a;
            b_q        <= grant_c ? req1_b  : req0_b;
            op_q       <= grant_c ? req1_op : req0_op;
            id_q       <= grant_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant_c;
`endif
         end
         if (state == EXEC) begin
            rsp_id       <= id_q;
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry;
         end
      end
   end

   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_op = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural 4-bit ALU.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected contention order.
module tb_alu_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
   logic [3:0] alu_a, alu_b, alu_op, alu_result;
   logic       alu_overflow, alu_zero, alu_carry;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [3:0] rsp_result;
   logic       rsp_overflow, rsp_zero, rsp_carry, busy;
   logic [4:0] alu_sum;

   int n_asserts = 0;
   int n_fail    = 0;

   alu_arbiter #(.DATA_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others yield 0
   always_comb begin
      alu_sum      = 5'd0;
      alu_result   = 4'd0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_op)
         4'd0: begin
            alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result   = alu_sum[3:0];
            alu_carry    = alu_sum[4];
            alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
         end
         4'd1: begin
            alu_sum      = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result   = alu_sum[3:0];
            alu_carry    = alu_sum[4];
            alu_overflow = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
         end
         4'd2:    alu_result = alu_a & alu_b;
         4'd3:    alu_result = alu_a | alu_b;
         4'd4:    alu_result = alu_a ^ alu_b;
         default: alu_result = 4'd0;
      endcase
      alu_zero = (alu_result == 4'd0);
   end

   logic [3:0] r0_a   [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
   logic [3:0] r0_res [4] = '{4'h2, 4'h3, 4'h4, 4'h5};
   logic [3:0] r1_a   [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
   logic [3:0] r1_res [4] = '{4'h3, 4'h2, 4'h1, 4'h0};
   logic       r1_z   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
   logic       exp_ids [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
   logic       exp_ids [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 of an IDLE-or-earlier cycle; returns at posedge+2 of the accept cycle
   task automatic wait_ready(output logic gid);
      logic got;
      got = 1'b0;
      gid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            got = 1'b1;
            gid = req1_ready;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("ready_seen", 32'(got), 32'd1);
      check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
   endtask

   task automatic do_op(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op, input logic [3:0] er, input logic ez, input logic ec,
                        input logic ev);
      logic gid;
      rsp_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
      wait_ready(gid);
      check({tag, "_grant"}, 32'(gid), 32'(id));
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check({tag, "_exec_drive"}, 32'({alu_a, alu_b, alu_op}), 32'({a, b, op}));
      check({tag, "_exec_status"}, 32'({busy, rsp_valid}), 32'b10);
      tick();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_rsp_result"}, 32'(rsp_result), 32'(er));
      check({tag, "_rsp_flags"}, 32'({rsp_zero, rsp_carry, rsp_overflow}), 32'({ez, ec, ev}));
      tick();
      check({tag, "_idle"}, 32'({rsp_valid, busy}), 32'd0);
   endtask

   task automatic drive_contention(input int n0, input int n1);
      req0_valid = (n0 < 4);
      if (n0 < 4) begin
         req0_a = r0_a[n0]; req0_b = 4'h1; req0_op = 4'h0;
      end
      req1_valid = (n1 < 4);
      if (n1 < 4) begin
         req1_a = r1_a[n1]; req1_b = 4'h3; req1_op = 4'h2;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic gid;
      int   n0, n1, e0, e1;
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_op = 4'h0;
      req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_op = 4'h0;
      rsp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset and idle: every output low
      for (int i = 0; i < 5; i++) begin
         check("reset_idle_outputs", 32'({req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid,
               rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_carry}), 32'd0);
         check("reset_idle_busy", 32'(busy), 32'd0);
         tick();
      end

      // Single req0 add with carry out
      do_op("add_7_9", 1'b0, 4'h7, 4'h9, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
      check("alu_hold_after_rsp", 32'({alu_a, alu_b, alu_op}), 32'h790);

      // Fresh reset so the pointer starts at 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_pointer_outputs", 32'({alu_a, alu_b, rsp_valid, busy}), 32'd0);

      // Continuous contention, four ops per requester
      rsp_ready = 1'b1;
      n0 = 0; n1 = 0; e0 = 0; e1 = 0;
      drive_contention(n0, n1);
      for (int t = 0; t < 8; t++) begin
         wait_ready(gid);
         check("contend_grant", 32'(gid), 32'(exp_ids[t]));
         tick();
         if (gid) n1++;
         else n0++;
         drive_contention(n0, n1);
         check("contend_no_ready_exec", 32'({req0_ready, req1_ready}), 32'd0);
         tick();
         check("contend_rsp_valid", 32'(rsp_valid), 32'd1);
         check("contend_rsp_id", 32'(rsp_id), 32'(exp_ids[t]));
         if (exp_ids[t]) begin
            check("contend_rsp_result", 32'(rsp_result), 32'(r1_res[e1]));
            check("contend_rsp_zero", 32'(rsp_zero), 32'(r1_z[e1]));
            e1++;
         end else begin
            check("contend_rsp_result", 32'(rsp_result), 32'(r0_res[e0]));
            check("contend_rsp_zero", 32'(rsp_zero), 32'd0);
            e0++;
         end
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Response stall with req1 waiting
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3; req0_op = 4'h0;
      wait_ready(gid);
      check("stall_grant", 32'(gid), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 4'hA; req1_b = 4'h5; req1_op = 4'h3;
      tick();
      for (int i = 0; i < 6; i++) begin
         check("stall_rsp_hold", 32'({rsp_valid, rsp_id, rsp_result}), 32'({1'b1, 1'b0, 4'h5}));
         check("stall_req1_ready", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("stall_release_idle", 32'(rsp_valid), 32'd0);
      check("stall_req1_first_idle", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      check("stall_req1_exec", 32'({alu_a, alu_b, alu_op}), 32'h0A53);
      tick();
      check("stall_req1_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero}), 32'({1'b1, 1'b1, 4'hF, 1'b0}));
      tick();

      // Reset while in EXEC discards the operation
      req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 4'h0;
      wait_ready(gid);
      tick();
      req0_valid = 1'b0;
      check("rstmid_in_exec", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_cleared", 32'({rsp_valid, busy, alu_a, alu_b}), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      end
      do_op("sub_5_3", 1'b0, 4'h5, 4'h3, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);

      // Unsupported op code forwarded unchanged
      do_op("op_c", 1'b1, 4'hF, 4'hF, 4'hC, 4'h0, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
